// File: rtl/inst_rom_boot.sv
// -----------------------------------------------------------------------------
// inst_rom_boot
//
// Instruction memory for the core's fetch port, filled at boot by a
// byte-serial loader. The fetch path is combinational so the IF/ID register
// captures the instruction at the next clock edge. The loader streams bytes
// (valid/ready, big-endian: first byte is the word's MSB) into a word-addressed
// RAM. The core is held in reset (cpu_hold_o) until the requested number of
// words has been written.
//
// Optional build macro:
//   INST_ROM_INIT_EN - leave reset in DONE, so the core runs without a load.
//                      The loader stays usable through ld_start_i.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   ce_i         - fetch enable from core
//   addr_i       - fetch byte address from core
//   inst_o       - fetched instruction (0 when disabled, not booted or out of range)
//   ld_start_i   - one-cycle pulse starting a load
//   ld_words_i   - words to load, sampled with ld_start_i, clamped to DEPTH
//   ld_valid_i   - loader byte valid
//   ld_data_i    - loader byte
//   ld_ready_o   - a byte is accepted this cycle when ld_valid_i is high
//   ld_count_o   - words written since the last start
//   boot_done_o  - image loaded, core may run
//   cpu_hold_o   - core reset request, always ~boot_done_o
// -----------------------------------------------------------------------------
module inst_rom_boot #(
    parameter int ADDR_W    = 10,
    parameter     INIT_FILE = "inst_rom.data"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    input  logic              ld_start_i,
    input  logic [ADDR_W:0]   ld_words_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    output logic              ld_ready_o,
    output logic [ADDR_W:0]   ld_count_o,
    output logic              boot_done_o,
    output logic              cpu_hold_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    // DEPTH expressed in the ld_words_i width for the clamp comparison
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef INST_ROM_INIT_EN
    localparam state_t RST_STATE = ST_DONE;
    localparam logic   RST_DONE  = 1'b1;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_DONE  = 1'b0;
`endif

    state_t              state_r;
    logic [1:0]          byte_cnt_r;
    logic [ADDR_W-1:0]   word_ptr_r;
    logic [ADDR_W:0]     target_r;
    logic [23:0]         buf_r;
    logic [31:0]         mem_r [DEPTH];

    logic [ADDR_W:0]     target_s;
    logic                last_word_s;
    logic                wr_en_s;
    logic [31:0]         wr_data_s;
    logic                addr_oob_s;
    logic                unused_addr_s;

    // Requests larger than the memory are clamped so the write pointer never wraps
    assign target_s    = (ld_words_i > DEPTH_V) ? DEPTH_V : ld_words_i;
    assign last_word_s = (({1'b0, word_ptr_r} + {{ADDR_W{1'b0}}, 1'b1}) == target_r);
    assign wr_en_s     = ~rst && (state_r == ST_LOAD) && ld_valid_i && ld_ready_o
                         && (byte_cnt_r == 2'd3);
    assign wr_data_s   = {buf_r, ld_data_i};
    assign addr_oob_s  = (addr_i[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
    // Byte offset is irrelevant for word fetches
    assign unused_addr_s = ^addr_i[1:0];

    // Loader FSM with registered handshake and boot status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RST_STATE;
            byte_cnt_r  <= 2'd0;
            word_ptr_r  <= {ADDR_W{1'b0}};
            target_r    <= {(ADDR_W+1){1'b0}};
            buf_r       <= 24'd0;
            ld_ready_o  <= 1'b0;
            ld_count_o  <= {(ADDR_W+1){1'b0}};
            boot_done_o <= RST_DONE;
            cpu_hold_o  <= ~RST_DONE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (ld_start_i) begin
                        byte_cnt_r <= 2'd0;
                        word_ptr_r <= {ADDR_W{1'b0}};
                        ld_count_o <= {(ADDR_W+1){1'b0}};
                        target_r   <= target_s;
                        if (target_s == {(ADDR_W+1){1'b0}}) begin
                            // Empty image: release the core immediately
                            state_r     <= ST_DONE;
                            ld_ready_o  <= 1'b0;
                            boot_done_o <= 1'b1;
                            cpu_hold_o  <= 1'b0;
                        end else begin
                            state_r     <= ST_LOAD;
                            ld_ready_o  <= 1'b1;
                            boot_done_o <= 1'b0;
                            cpu_hold_o  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // ld_start_i is deliberately ignored while loading
                    if (ld_valid_i && ld_ready_o) begin
                        if (byte_cnt_r == 2'd3) begin
                            // Fourth byte completes the word; memory write happens at this edge
                            byte_cnt_r <= 2'd0;
                            word_ptr_r <= word_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            ld_count_o <= ld_count_o + {{ADDR_W{1'b0}}, 1'b1};
                            if (last_word_s) begin
                                state_r     <= ST_DONE;
                                ld_ready_o  <= 1'b0;
                                boot_done_o <= 1'b1;
                                cpu_hold_o  <= 1'b0;
                            end
                        end else begin
                            buf_r      <= {buf_r[15:0], ld_data_i};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end
                end
                default: begin
                    state_r     <= RST_STATE;
                    ld_ready_o  <= 1'b0;
                    boot_done_o <= RST_DONE;
                    cpu_hold_o  <= ~RST_DONE;
                end
            endcase
        end
    end

    // Word write port; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[word_ptr_r] <= wr_data_s;
        end
    end

    // Same-cycle fetch; zero whenever the core must not see memory contents
    always_comb begin
        inst_o = 32'd0;
        if (rst || !ce_i || (state_r != ST_DONE) || addr_oob_s) begin
            inst_o = 32'd0;
        end else begin
            inst_o = mem_r[addr_i[ADDR_W+1:2]];
        end
    end

endmodule

// File: tb/tb_inst_rom_boot.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_boot
//
// Self-checking bench for inst_rom_boot (ADDR_W=10). Expected values are
// pushed to a scoreboard queue when stimulus is applied and popped when the
// corresponding DUT output is sampled. A bench-side image of the memory is
// updated as words are streamed in and used to predict fetch results.
// -----------------------------------------------------------------------------
module tb_inst_rom_boot;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              rst;
    logic              ce;
    logic [31:0]       addr;
    logic [31:0]       inst;
    logic              ld_start;
    logic [ADDR_W:0]   ld_words;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              boot_done;
    logic              cpu_hold;

    int checks_r   = 0;
    int failures_r = 0;

    logic [31:0] sb_exp_q[$];
    string       sb_tag_q[$];
    logic [31:0] model_mem [DEPTH];

    inst_rom_boot #(.ADDR_W(ADDR_W), .INIT_FILE("inst_rom.data")) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .addr_i      (addr),
        .inst_o      (inst),
        .ld_start_i  (ld_start),
        .ld_words_i  (ld_words),
        .ld_valid_i  (ld_valid),
        .ld_data_i   (ld_data),
        .ld_ready_o  (ld_ready),
        .ld_count_o  (ld_count),
        .boot_done_o (boot_done),
        .cpu_hold_o  (cpu_hold)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_exp_q.push_back(exp);
        sb_tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        if (sb_exp_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_exp_q.pop_front();
            t = sb_tag_q.pop_front();
            check_val(t, obs, e);
        end
    endtask

    // Sample a status output now (called mid-cycle, away from the edge)
    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop(obs);
    endtask

    // Apply a fetch at a negedge and compare the combinational instruction
    task automatic fetch(input string tag, input logic c, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        ce   = c;
        addr = a;
        sb_push(tag, exp);
        #1;
        sb_pop(inst);
        ce = 1'b0;
    endtask

    // Pulse ld_start_i for one cycle; returns at the negedge after the edge
    task automatic start_load(input logic [ADDR_W:0] words);
        ld_start = 1'b1;
        ld_words = words;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Offer one byte; returns at the negedge after it was accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_data  = b;
        while (ld_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input int gap);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[k*8 +: 8]);
            if (gap > 0) idle_cycles(gap);
        end
        model_mem[idx] = w;
    endtask

    initial begin
        logic [31:0] w;
        rst      = 1'b1;
        ce       = 1'b0;
        addr     = 32'd0;
        ld_start = 1'b0;
        ld_words = '0;
        ld_valid = 1'b0;
        ld_data  = 8'd0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;

        idle_cycles(2);
        ce = 1'b1;
        #1;
        expect_now("inst_in_rst", inst, 32'd0);
        ce = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        expect_now("rst_ready", {31'd0, ld_ready}, 32'd0);
        expect_now("rst_count", {21'd0, ld_count}, 32'd0);
`ifdef INST_ROM_INIT_EN
        expect_now("rst_done", {31'd0, boot_done}, 32'd1);
        expect_now("rst_hold", {31'd0, cpu_hold}, 32'd0);
`else
        expect_now("rst_done", {31'd0, boot_done}, 32'd0);
        expect_now("rst_hold", {31'd0, cpu_hold}, 32'd1);
        fetch("fetch_idle", 1'b1, 32'd0, 32'd0);
`endif

        // Two-word load with gaps in ld_valid_i
        start_load(11'd2);
        expect_now("load_ready", {31'd0, ld_ready}, 32'd1);
        expect_now("load_hold", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h34020020, 0, 1);
        expect_now("cnt_after_w0", {21'd0, ld_count}, 32'd1);
        send_byte(8'h34); idle_cycles(2);
        send_byte(8'h03); idle_cycles(1);
        send_byte(8'hFF);
        ld_valid = 1'b1;
        ld_data  = 8'hFF;
        #1;
        expect_now("done_before_last", {31'd0, boot_done}, 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        model_mem[1] = 32'h3403FFFF;
        expect_now("done_after_last", {31'd0, boot_done}, 32'd1);
        expect_now("hold_after_last", {31'd0, cpu_hold}, 32'd0);
        expect_now("ready_after_last", {31'd0, ld_ready}, 32'd0);
        expect_now("count_after_load", {21'd0, ld_count}, 32'd2);

        // Fetch path
        fetch("fetch_w0", 1'b1, 32'h0, 32'h34020020);
        fetch("fetch_w1", 1'b1, 32'h4, 32'h3403FFFF);
        fetch("fetch_w1_off", 1'b1, 32'h5, 32'h3403FFFF);
        fetch("fetch_oob", 1'b1, 32'h00001000, 32'd0);
        fetch("fetch_oob_hi", 1'b1, 32'h80000004, 32'd0);
        fetch("fetch_ce0", 1'b0, 32'h4, 32'd0);

        // Reset after 5 bytes: word 0 written, partial word 1 discarded
        start_load(11'd2);
        send_word(32'h11223344, 0, 0);
        send_byte(8'h55);
        rst = 1'b1;
        #1;
        expect_now("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
        expect_now("mid_rst_done", {31'd0, boot_done}, 32'd0);
        expect_now("mid_rst_count", {21'd0, ld_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero-word start goes straight to DONE, exposing preserved memory
        start_load(11'd0);
        expect_now("zero_done", {31'd0, boot_done}, 32'd1);
        expect_now("zero_ready", {31'd0, ld_ready}, 32'd0);
        expect_now("zero_count", {21'd0, ld_count}, 32'd0);
        @(negedge clk);
        expect_now("zero_ready_later", {31'd0, ld_ready}, 32'd0);
        fetch("keep_w0", 1'b1, 32'h0, model_mem[0]);
        fetch("keep_w1", 1'b1, 32'h4, model_mem[1]);

        // Reload from word 0 after the interrupted load
        start_load(11'd2);
        send_word(32'hDEADBEEF, 0, 0);
        send_word(32'h01234567, 1, 0);
        fetch("reload_w0", 1'b1, 32'h0, model_mem[0]);
        fetch("reload_w1", 1'b1, 32'h4, model_mem[1]);

        // Oversized request clamps to DEPTH words
        start_load(11'd2047);
        for (int i = 0; i < DEPTH; i++) begin
            w = {i[15:0] ^ 16'hA5A5, i[15:0]};
            if (i == DEPTH - 1) begin
                expect_now("clamp_cnt_pre", {21'd0, ld_count}, DEPTH - 1);
                expect_now("clamp_done_pre", {31'd0, boot_done}, 32'd0);
            end
            send_word(w, i, 0);
        end
        expect_now("clamp_done", {31'd0, boot_done}, 32'd1);
        expect_now("clamp_ready", {31'd0, ld_ready}, 32'd0);
        expect_now("clamp_count", {21'd0, ld_count}, DEPTH);
        fetch("clamp_first", 1'b1, 32'h0, model_mem[0]);
        fetch("clamp_mid", 1'b1, 32'h800, model_mem[512]);
        fetch("clamp_last", 1'b1, 32'hFFC, model_mem[1023]);

        // Reload from DONE; a second start during LOAD is ignored
        start_load(11'd1);
        expect_now("reload_done_low", {31'd0, boot_done}, 32'd0);
        expect_now("reload_hold", {31'd0, cpu_hold}, 32'd1);
        ce   = 1'b1;
        addr = 32'h0;
        #1;
        expect_now("reload_inst_zero", inst, 32'd0);
        ce = 1'b0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        start_load(11'd3);
        send_byte(8'hCC);
        send_byte(8'hDD);
        model_mem[0] = 32'hAABBCCDD;
        expect_now("reload2_done", {31'd0, boot_done}, 32'd1);
        expect_now("reload2_count", {21'd0, ld_count}, 32'd1);
        expect_now("reload2_ready", {31'd0, ld_ready}, 32'd0);
        fetch("reload2_w0", 1'b1, 32'h0, model_mem[0]);
        fetch("reload2_w1", 1'b1, 32'h4, model_mem[1]);

        if (sb_exp_q.size() != 0) check_val("sb_leftover", sb_exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
